mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the fetch stage and the load/store stage of the CPU. The block arbitrates one access per cycle, drives the memory port, and routes the synchronous read data back to the requester that issued the read. Data accesses normally win. A starvation counter guarantees fetch progress. It sits between the pipeline front/back ends and the memory array.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_starve_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared CPU memory-port constants and read-owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int CPU_ADDR_W = 30;
    localparam int CPU_DATA_W = 32;

    typedef logic [1:0] rd_owner_t;

    localparam rd_owner_t RD_NONE = 2'd0;
    localparam rd_owner_t RD_IF   = 2'd1;
    localparam rd_owner_t RD_D    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : starve_counter
// Description : Saturating count of fetch-denied data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int STREAK_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [STREAK_W-1:0] c_limit = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] r_streak;

    // Clear has priority so a fetch grant always restarts the count
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_streak <= '0;
        end else if (i_inc && (r_streak != c_limit)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign o_at_limit = (r_streak == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fetch/data arbiter for a shared single-port synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = CPU_ADDR_W,
    parameter int DATA_W       = CPU_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int STREAK_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_at_limit;
    logic              w_if_win;
    logic              w_d_win;
    rd_owner_t         r_rd_owner;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_d_hold;

    // Data wins contention unless fetch has been starved long enough
    assign w_if_win = if_req && (!d_req || w_at_limit);
    assign w_d_win  = d_req && !w_if_win;

    assign if_gnt    = w_if_win && !rst;
    assign d_gnt     = w_d_win && !rst;
    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STREAK_W     (STREAK_W)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (d_gnt && if_req),
        .i_clr      (if_gnt || !if_req),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= RD_NONE;
        end else if (if_gnt) begin
            r_rd_owner <= RD_IF;
        end else if (d_gnt && !d_we) begin
            r_rd_owner <= RD_D;
        end else begin
            r_rd_owner <= RD_NONE;
        end
    end

    assign if_rvalid = (r_rd_owner == RD_IF);
    assign d_rvalid  = (r_rd_owner == RD_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (if_rvalid) r_if_hold <= mem_rdata;
            if (d_rvalid)  r_d_hold  <= mem_rdata;
        end
    end

    // Read data passes straight through in its valid cycle, then holds
    assign if_rdata = if_rvalid ? mem_rdata : r_if_hold;
    assign d_rdata  = d_rvalid  ? mem_rdata : r_d_hold;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench with a behavioural sync memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int total;
    int bad;

    logic [DATA_W-1:0] mem [0:255];

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4),
        .STREAK_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'h2404_0006;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 30'd1; d_addr = 30'd1; d_wdata = '0;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en} !== 5'b0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got gnt/rv/en=%b want 00000", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en});
            end
            next_cycle();
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got if_rdata=%h d_rdata=%h mem_en=%b want 0 0 0",
                     if_rdata, d_rdata, mem_en);
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 30'd1;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'd1) begin
            bad++;
            $display("FAIL fetch_grant: got if_gnt=%b d_gnt=%b en=%b we=%b addr=%0d want 1 0 1 0 1",
                     if_gnt, d_gnt, mem_en, mem_we, mem_addr);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h2404_0006 || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_resp: got if_rvalid=%b if_rdata=%h d_rvalid=%b want 1 24040006 0",
                     if_rvalid, if_rdata, d_rvalid);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h2404_0006) begin
            bad++;
            $display("FAIL fetch_hold: got if_rvalid=%b if_rdata=%h want 0 24040006", if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'd8; d_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'd8 || mem_wdata !== 32'hAABB_CCDD) begin
            bad++;
            $display("FAIL store_grant: got d_gnt=%b en=%b we=%b addr=%0d wdata=%h want 1 1 1 8 aabbccdd",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0 || d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL load_grant: got d_gnt=%b we=%b d_rvalid=%b want 1 0 0", d_gnt, mem_we, d_rvalid);
        end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hAABB_CCDD || if_rvalid !== 1'b0 || if_rdata !== 32'h2404_0006) begin
            bad++;
            $display("FAIL load_resp: got d_rvalid=%b d_rdata=%h if_rvalid=%b if_rdata=%h want 1 aabbccdd 0 24040006",
                     d_rvalid, d_rdata, if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [9:0] exp_if;
        logic       prev_if;
        logic       prev_d;
        exp_if  = 10'b10_0001_0000;
        prev_if = 1'b0;
        prev_d  = 1'b0;
        if_req = 1'b1; if_addr = 30'd1;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 30'd8;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (if_gnt !== exp_if[c] || d_gnt !== !exp_if[c] || if_rvalid !== prev_if || d_rvalid !== prev_d) begin
                bad++;
                $display("FAIL contention cycle %0d: got if_gnt=%b d_gnt=%b if_rv=%b d_rv=%b want %b %b %b %b",
                         c + 1, if_gnt, d_gnt, if_rvalid, d_rvalid, exp_if[c], !exp_if[c], prev_if, prev_d);
            end
            prev_if = exp_if[c];
            prev_d  = !exp_if[c];
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h2404_0006 || d_rvalid !== 1'b0 || d_rdata !== 32'hAABB_CCDD) begin
            bad++;
            $display("FAIL contention_tail: got if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h want 1 24040006 0 aabbccdd",
                     if_rvalid, if_rdata, d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data [3];
        exp_data[0] = 32'h2404_0006;
        exp_data[1] = 32'h0;
        exp_data[2] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if_req  = (c < 3);
            if_addr = 30'(c + 1);
            @(negedge clk);
            if (c < 3) begin
                total++;
                if (if_gnt !== 1'b1 || mem_addr !== 30'(c + 1)) begin
                    bad++;
                    $display("FAIL b2b_grant %0d: got if_gnt=%b addr=%0d want 1 %0d", c, if_gnt, mem_addr, c + 1);
                end
            end
            if (c > 0) begin
                total++;
                if (if_rvalid !== 1'b1 || if_rdata !== exp_data[c - 1]) begin
                    bad++;
                    $display("FAIL b2b_resp %0d: got if_rvalid=%b if_rdata=%h want 1 %h",
                             c - 1, if_rvalid, if_rdata, exp_data[c - 1]);
                end
            end
            next_cycle();
        end
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL b2b_end: got if_rvalid=%b if_rdata=%h want 0 00000000", if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        // Reload a nonzero fetch word so the reset-clear of both holds is visible
        if_req = 1'b1; if_addr = 30'd1;
        next_cycle();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd1; rst = 1'b1;
        @(negedge clk);
        total++;
        if (d_rdata !== 32'hAABB_CCDD || if_rdata !== 32'h2404_0006) begin
            bad++;
            $display("FAIL pre_reset_hold: got d_rdata=%h if_rdata=%h want aabbccdd 24040006", d_rdata, if_rdata);
        end
        next_cycle();
        rst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: got d_rv=%b d_rdata=%h if_rv=%b if_rdata=%h want 0 0 0 0",
                     d_rvalid, d_rdata, if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
